// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM states and the active-low strobe bundle.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  typedef struct packed {
    logic ce;
    logic ub;
    logic lb;
    logic oe;
    logic we;
  } strobe_t;

  localparam strobe_t SRAM_IDLE = '1;

endpackage

// File: rtl/sram_arbiter_rr_grant2.sv
// Two-requester round-robin grant; `last` remembers the most recently accepted port.
module rr_grant2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_id
);

  logic last;

  // Resetting to 1 lets port 0 win the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= 1'b1;
    else if (accept) last <= gnt_id;
  end

  always_comb begin
    gnt_id = 1'b0;
    if (req == 2'b11) gnt_id = ~last;
    else if (req[1])  gnt_id = 1'b1;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: round-robin grant, request latching and fixed-timing strobe sequencing.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              id_q;
  logic [1:0]        done_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  strobe_t           stb;

  logic              gnt_id, idle, accept, rd_last;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_grant2 u_grant (
    .clk    (Clk),
    .rst_n  (Reset),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .gnt_id (gnt_id)
  );

  assign idle       = (state == ST_IDLE);
  assign req0_ready = idle && Reset && req0_valid && !gnt_id;
  assign req1_ready = idle && Reset && req1_valid &&  gnt_id;
  assign accept     = req0_ready || req1_ready;
  assign rd_last    = (state == ST_RD) && (cnt == '0);

  assign sel_we    = gnt_id ? req1_we    : req0_we;
  assign sel_addr  = gnt_id ? req1_addr  : req0_addr;
  assign sel_wdata = gnt_id ? req1_wdata : req0_wdata;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter is reloaded on every state entry and counts down to zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = sel_we ? ST_WR_SETUP : ST_RD;
          cnt_nxt   = sel_we ? '0 : RD_LOAD;
        end
      end
      ST_RD: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_WR_SETUP: begin
        state_nxt = ST_WR_PULSE;
        cnt_nxt   = WR_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt == '0) begin
          state_nxt = ST_WR_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_WR_HOLD: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    stb = SRAM_IDLE;
    case (state)
      ST_RD:       begin stb.ce = 1'b0; stb.ub = 1'b0; stb.lb = 1'b0; stb.oe = 1'b0; end
      ST_WR_SETUP: begin stb.ce = 1'b0; stb.ub = 1'b0; stb.lb = 1'b0; end
      ST_WR_PULSE: begin stb.ce = 1'b0; stb.ub = 1'b0; stb.lb = 1'b0; stb.we = 1'b0; end
      ST_WR_HOLD:  begin stb.ce = 1'b0; stb.ub = 1'b0; stb.lb = 1'b0; end
      default:     stb = SRAM_IDLE;
    endcase
  end

  assign CE = stb.ce;
  assign UB = stb.ub;
  assign LB = stb.lb;
  assign OE = stb.oe;
  assign WE = stb.we;

  // Address and write data change only at accept, so they are stable whenever CE is low.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      id_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      id_q    <= gnt_id;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      done_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      done_q <= '0;
      if (rd_last || (state == ST_WR_HOLD)) done_q[id_q] <= 1'b1;
      if (rd_last) begin
        if (id_q) rdata1_q <= Data_from_SRAM;
        else      rdata0_q <= Data_from_SRAM;
      end
    end
  end

  assign ADDR         = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign req0_done    = done_q[0];
  assign req1_done    = done_q[1];
  assign req0_rdata   = rdata0_q;
  assign req1_rdata   = rdata1_q;

endmodule
